// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared encodings for the memory port arbiter
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } arb_owner_t;

   localparam logic [2:0] LIM_B = 3'd0;
   localparam logic [2:0] LIM_H = 3'd1;
   localparam logic [2:0] LIM_W = 3'd3;

endpackage

// File: rtl/mem_port_arbiter_timeout_counter.sv
// rtl/mem_port_arbiter_timeout_counter.sv - saturating BUSY-cycle counter for timeout completion
module arb_timeout_counter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic CLR,
   input  logic EN,
   output logic EXPIRED
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign EXPIRED = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (CLR) begin
         cnt_d = '0;
      end else if (EN && !EXPIRED) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - D-over-I arbiter for the shared memory port, one transaction in flight
// MEM_TIMEOUT_EN: completes a stalled transaction with ERR=1 after TIMEOUT_CYCLES BUSY cycles.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          I_REQ,
   input  logic [AW-1:0] I_ADDR,
   input  logic          D_REQ,
   input  logic          D_WE,
   input  logic [AW-1:0] D_ADDR,
   input  logic [DW-1:0] D_WDATA,
   input  logic [2:0]    D_LIM,
   input  logic          D_SIGNED,
   output logic          I_ACK,
   output logic          D_ACK,
   output logic [DW-1:0] RDATA,
   output logic          ERR,
   output logic          BUSY,
   output logic          M_REQ,
   output logic          M_WE,
   output logic [AW-1:0] M_ADDR,
   output logic [DW-1:0] M_WDATA,
   output logic [2:0]    M_LIM,
   output logic          M_SIGNED,
   input  logic          M_RDY,
   input  logic [DW-1:0] M_RDATA
);

   arb_state_t    state_q;
   arb_owner_t    owner_q;
   logic          i_ack_q, d_ack_q, m_req_q, m_we_q, m_signed_q;
   logic [AW-1:0] m_addr_q;
   logic [DW-1:0] m_wdata_q, rdata_q;
   logic [2:0]    m_lim_q;
   logic          timeout_hit;

`ifdef MEM_TIMEOUT_EN
   logic err_q;

   arb_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK    (CLK),
      .RST    (RST),
      .CLR    (state_q == ST_IDLE),
      .EN     ((state_q == ST_BUSY) && !M_RDY),
      .EXPIRED(timeout_hit)
   );

   assign ERR = err_q;
`else
   logic unused_cfg;

   assign unused_cfg  = (TIMEOUT_CYCLES == 0);
   assign timeout_hit = 1'b0;
   assign ERR         = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_NONE;
         i_ack_q    <= 1'b0;
         d_ack_q    <= 1'b0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_signed_q <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         m_lim_q    <= '0;
         rdata_q    <= '0;
`ifdef MEM_TIMEOUT_EN
         err_q      <= 1'b0;
`endif
      end else begin
         m_req_q <= 1'b0;
         i_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (D_REQ) begin
                  owner_q    <= OWN_D;
                  m_we_q     <= D_WE;
                  m_addr_q   <= D_ADDR;
                  m_wdata_q  <= D_WDATA;
                  m_lim_q    <= D_LIM;
                  m_signed_q <= D_SIGNED;
                  m_req_q    <= 1'b1;
                  state_q    <= ST_BUSY;
               end else if (I_REQ) begin
                  // Fetches are always unsigned word reads; M_WDATA keeps the last store data.
                  owner_q    <= OWN_I;
                  m_we_q     <= 1'b0;
                  m_addr_q   <= I_ADDR;
                  m_lim_q    <= LIM_W;
                  m_signed_q <= 1'b0;
                  m_req_q    <= 1'b1;
                  state_q    <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (M_RDY || timeout_hit) begin
                  rdata_q <= (m_we_q || !M_RDY) ? '0 : M_RDATA;
`ifdef MEM_TIMEOUT_EN
                  err_q   <= !M_RDY;
`endif
                  i_ack_q <= (owner_q == OWN_I);
                  d_ack_q <= (owner_q == OWN_D);
                  state_q <= ST_RESP;
               end
            end
            ST_RESP: begin
               owner_q <= OWN_NONE;
               state_q <= ST_IDLE;
            end
            default: begin
               owner_q <= OWN_NONE;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign I_ACK    = i_ack_q;
   assign D_ACK    = d_ack_q;
   assign RDATA    = rdata_q;
   assign BUSY     = (state_q != ST_IDLE);
   assign M_REQ    = m_req_q;
   assign M_WE     = m_we_q;
   assign M_ADDR   = m_addr_q;
   assign M_WDATA  = m_wdata_q;
   assign M_LIM    = m_lim_q;
   assign M_SIGNED = m_signed_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, d_signed, m_rdy;
   logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
   logic [2:0]  d_lim;
   logic        i_ack, d_ack, err, busy, m_req, m_we, m_signed;
   logic [31:0] rdata, m_addr, m_wdata;
   logic [2:0]  m_lim;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_wdata = 32'h0;
   logic [31:0] last_rdata = 32'h0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .AW(32), .DW(32), .TIMEOUT_CYCLES(4)
   ) dut (
      .CLK(clk), .RST(rst),
      .I_REQ(i_req), .I_ADDR(i_addr),
      .D_REQ(d_req), .D_WE(d_we), .D_ADDR(d_addr), .D_WDATA(d_wdata),
      .D_LIM(d_lim), .D_SIGNED(d_signed),
      .I_ACK(i_ack), .D_ACK(d_ack), .RDATA(rdata), .ERR(err), .BUSY(busy),
      .M_REQ(m_req), .M_WE(m_we), .M_ADDR(m_addr), .M_WDATA(m_wdata),
      .M_LIM(m_lim), .M_SIGNED(m_signed),
      .M_RDY(m_rdy), .M_RDATA(m_rdata)
   );

   typedef struct {
      bit          is_d;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  lim;
      bit          sgn;
      int          wt;
      logic [31:0] mrd;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic txn(input vec_t v);
      int mreq_cnt;
      int busy_cnt;
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
         d_lim = v.lim; d_signed = v.sgn;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      step();
      chk("grant_mreq", 32'(m_req), 32'd1);
      chk("m_addr", m_addr, v.addr);
      chk("m_we", 32'(m_we), v.is_d ? 32'(v.we) : 32'd0);
      chk("m_lim", 32'(m_lim), v.is_d ? 32'(v.lim) : 32'd3);
      chk("m_signed", 32'(m_signed), v.is_d ? 32'(v.sgn) : 32'd0);
      if (v.is_d) last_wdata = v.wdata;
      chk("m_wdata", m_wdata, last_wdata);
      mreq_cnt = 1;
      busy_cnt = 1;
      for (int k = 0; k < v.wt; k++) begin
         step();
         mreq_cnt += int'(m_req);
         busy_cnt += int'(busy);
         chk("early_ack", 32'({i_ack, d_ack}), 32'd0);
      end
      m_rdy = 1'b1;
      m_rdata = v.mrd;
      step();
      m_rdy = 1'b0;
      m_rdata = 32'h0;
      busy_cnt += int'(busy);
      chk("i_ack", 32'(i_ack), v.is_d ? 32'd0 : 32'd1);
      chk("d_ack", 32'(d_ack), v.is_d ? 32'd1 : 32'd0);
      chk("rdata", rdata, v.exp_rdata);
      chk("err", 32'(err), 32'd0);
      last_rdata = v.exp_rdata;
      if (v.is_d) d_req = 1'b0;
      else i_req = 1'b0;
      step();
      chk("idle_busy", 32'(busy), 32'd0);
      chk("ack_one_cycle", 32'({i_ack, d_ack}), 32'd0);
      chk("mreq_pulses", 32'(mreq_cnt), 32'd1);
      chk("busy_cycles", 32'(busy_cnt), 32'(v.wt + 2));
   endtask

   initial begin
      vec_t cv;
      rst = 1'b1;
      i_req = 0; d_req = 0; d_we = 0; d_signed = 0; m_rdy = 0;
      i_addr = 0; d_addr = 0; d_wdata = 0; m_rdata = 0; d_lim = 0;

      vecs[0] = '{is_d:0, we:0, addr:32'h100,  wdata:32'h0,         lim:3'd3, sgn:0, wt:2, mrd:32'hDEADBEEF, exp_rdata:32'hDEADBEEF};
      vecs[1] = '{is_d:1, we:0, addr:32'h41,   wdata:32'hAAAA0000,  lim:3'd0, sgn:1, wt:1, mrd:32'h000000F0, exp_rdata:32'h000000F0};
      vecs[2] = '{is_d:1, we:1, addr:32'h80,   wdata:32'h12345678,  lim:3'd3, sgn:0, wt:0, mrd:32'hFFFFFFFF, exp_rdata:32'h0};
      vecs[3] = '{is_d:0, we:0, addr:32'h104,  wdata:32'h0,         lim:3'd3, sgn:0, wt:0, mrd:32'h0BADF00D, exp_rdata:32'h0BADF00D};

      #12;
      chk("rst_outs", {m_addr[15:0], 6'(0), m_lim, m_req, m_we, m_signed, i_ack, d_ack, err, busy}, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      step();
      rst = 1'b0;
      step();

      for (int n = 0; n < 4; n++) txn(vecs[n]);

      // Contention: both rise together, D store must win, I follows.
      i_req = 1'b1;
      i_addr = 32'h300;
      cv = '{is_d:1, we:1, addr:32'h2000, wdata:32'h55, lim:3'd0, sgn:0, wt:1, mrd:32'h77777777, exp_rdata:32'h0};
      txn(cv);
      cv = '{is_d:0, we:0, addr:32'h300, wdata:32'h0, lim:3'd3, sgn:0, wt:2, mrd:32'hCAFEF00D, exp_rdata:32'hCAFEF00D};
      txn(cv);

      // Spurious M_RDY while idle.
      m_rdy = 1'b1;
      m_rdata = 32'h1234;
      step();
      m_rdy = 1'b0;
      chk("spur_ack", 32'({i_ack, d_ack}), 32'd0);
      step();
      chk("spur_ack2", 32'({i_ack, d_ack}), 32'd0);
      chk("spur_rdata", rdata, last_rdata);
      chk("spur_busy", 32'(busy), 32'd0);

      // Async reset mid-BUSY, late M_RDY afterwards.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h900; d_wdata = 32'hF00D; d_lim = 3'd1;
      step();
      chk("rstb_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      d_req = 1'b0;
      #1;
      chk("rstb_outs", {m_addr[15:0], 6'(0), m_lim, m_req, m_we, m_signed, i_ack, d_ack, err, busy}, 32'h0);
      chk("rstb_wdata", m_wdata, 32'h0);
      chk("rstb_rdata", rdata, 32'h0);
      step();
      rst = 1'b0;
      step();
      m_rdy = 1'b1;
      m_rdata = 32'h5A5A5A5A;
      step();
      m_rdy = 1'b0;
      chk("rstb_late_ack", 32'({i_ack, d_ack, busy}), 32'd0);
      step();
      chk("rstb_late_ack2", 32'({i_ack, d_ack, busy}), 32'd0);
      chk("rstb_late_rdata", rdata, 32'h0);

      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h500; d_lim = 3'd3;
      step();
      chk("to_mreq", 32'(m_req), 32'd1);
`ifdef MEM_TIMEOUT_EN
      rdata_seed();
      for (int k = 0; k < 3; k++) begin
         step();
         chk("to_early_ack", 32'({i_ack, d_ack}), 32'd0);
      end
      step();
      chk("to_d_ack", 32'(d_ack), 32'd1);
      chk("to_err", 32'(err), 32'd1);
      chk("to_rdata", rdata, 32'h0);
      d_req = 1'b0;
      step();
      m_rdy = 1'b1;
      m_rdata = 32'h99;
      step();
      m_rdy = 1'b0;
      chk("to_late_ack", 32'({i_ack, d_ack, busy}), 32'd0);
      step();
      chk("to_late_ack2", 32'({i_ack, d_ack, busy}), 32'd0);
      chk("to_late_rdata", rdata, 32'h0);
`else
      for (int k = 0; k < 20; k++) begin
         step();
         chk("hold_busy", 32'({busy, i_ack, d_ack}), 32'd4);
      end
      chk("hold_err", 32'(err), 32'd0);
      rst = 1'b1;
      d_req = 1'b0;
      step();
      rst = 1'b0;
      step();
      chk("hold_recover", 32'(busy), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

`ifdef MEM_TIMEOUT_EN
   task automatic rdata_seed();
      m_rdy = 1'b0;
      m_rdata = 32'hEEEEEEEE;
   endtask
`endif

endmodule
